lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store unit on the consumer side of the CPU ALU's address path.
- Accepts one load/store request from EX: address = ALU sum of rs1 + imm, plus rs2 store data.
- Drives a single-outstanding req/gnt/rvalid data-memory port.
- Returns sign/zero-extended load data to writeback; flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYC, 255: max cycles waiting for mem_gnt or mem_rvalid before bus_err; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  EX presents a memory op
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_opcode  in  5  instr[6:2]; 5'b00000 load, 5'b01000 store, others ignored
- req_func3  in  3  width/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  {req_addr[31:2],2'b00}
- mem_wstrb  out  4  byte-lane write enables
- mem_wdata  out  32  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  read data valid (or write ack)
- mem_rdata  in  32  read word
- wb_valid  out  1  one-cycle load result pulse
- wb_rd  out  5  destination register
- wb_data  out  32  extended load data
- misalign_exc  out  1  one-cycle pulse
- bus_err  out  1  one-cycle pulse
- busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE; all outputs 0 except req_ready=1. Reset mid-transaction aborts the transaction: no wb_valid, no pulses.
- Request accept:
  - Accept on req_valid & req_ready with a valid opcode. Latch opcode, func3, addr, wdata, rd.
  - Unknown opcode: not accepted, req_ready stays 1, no effect.
- Misalignment:
  - Halfword ops require addr[0]=0; word ops require addr[1:0]=0.
  - Misaligned: next state EXC, which pulses misalign_exc for 1 cycle and returns to IDLE. mem_req never asserts.
- FSM:
  - IDLE -> REQ on aligned accept.
  - REQ: mem_req=1 with addr/we/wstrb/wdata held stable until mem_gnt.
    - On gnt, store -> IDLE; load -> WAIT_R.
  - WAIT_R: on mem_rvalid, register the extended data.
    - Next cycle is RESP: wb_valid=1, wb_rd, wb_data; then IDLE.
  - mem_rvalid in the same cycle as gnt is ignored; data is expected no earlier than the cycle after gnt.
- Store lanes:
  - sb: wstrb = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - sh: wstrb = 4'b0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - sw: wstrb = 4'b1111.
  - mem_we=0 and wstrb=0 for loads.
- Load extract: select byte/half by addr[1:0]. lb/lh sign-extend; lbu/lhu zero-extend; lw passes through.
- Min latency:
  - Load: accept cycle 0, gnt cycle 1, rvalid cycle 2, wb_valid cycle 3.
  - Store: accept cycle 0, gnt cycle 1, req_ready cycle 2.
- Timeout:
  - An 8+ bit counter clears on entering REQ/WAIT_R and increments each waiting cycle.
  - Reaching TIMEOUT_CYC pulses bus_err for 1 cycle, deasserts mem_req, and returns to IDLE. No wb_valid is issued.
  - The counter saturates and never wraps.
- Only one outstanding transaction at a time; req_valid while busy is held off by req_ready=0.

Optional Feature:
- LSU_STORE_ACK_EN defined: stores enter WAIT_R after gnt and complete on mem_rvalid (write response), with no wb_valid. The timeout applies.
- Undefined: stores complete at gnt and mem_rvalid is ignored for stores.

Test Plan:
- lw from 0x0000_1004, gnt cycle 1, rdata 0xDEADBEEF at cycle 2 -> mem_addr 0x1004, wb_valid cycle 3, wb_data 0xDEADBEEF, wb_rd echoed.
- lb addr 0x...03 and lbu addr 0x...03 with rdata 0x80112233 -> wb_data 0xFFFFFF80 and 0x00000080; lh addr 0x...2 -> 0xFFFF8011.
- sb addr 0x102 wdata 0x000000A5 -> mem_we=1, wstrb 4'b0100, wdata 0xA5A5A5A5, mem_addr 0x100; sh addr 0x102 -> wstrb 4'b1100.
- lw addr 0x1002 and sh addr 0x1001 -> misalign_exc pulse 1 cycle after accept, mem_req never high, req_ready back to 1.
- TIMEOUT_CYC=4, mem_gnt held 0 -> bus_err pulse after 4 REQ cycles, mem_req drops, no wb_valid; repeat stalling rvalid in WAIT_R -> same result.
- Assert rst_n low in WAIT_R -> all outputs 0 and req_ready=1 asynchronously; a late mem_rvalid after reset produces no wb_valid.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit: takes one EX memory op, drives a single-outstanding req/gnt/rvalid
// data port, extends load data for writeback. Optional macro LSU_STORE_ACK_EN: stores wait for a write ack.
//
// state    | meaning
// IDLE     | ready for a new request
// REQ      | mem_req held until mem_gnt
// WAIT_R   | waiting for mem_rvalid
// RESP     | wb_valid pulse with extended load data
// EXC      | misalign_exc pulse
// ERR      | bus_err pulse after a timeout
module lsu_ctrl #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [4:0]  i_req_opcode,
  input  logic [2:0]  i_req_func3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_wstrb,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_wb_valid,
  output logic [4:0]  o_wb_rd,
  output logic [31:0] o_wb_data,
  output logic        o_misalign_exc,
  output logic        o_bus_err,
  output logic        o_busy
);

  localparam logic [4:0] OP_LOAD  = 5'b00000;
  localparam logic [4:0] OP_STORE = 5'b01000;
  localparam int CW = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CW-1:0] TC_LAST = CW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic TMO_EN = (TIMEOUT_CYC > 0);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT_R, S_RESP, S_EXC, S_ERR
  } state_t;

  state_t r_state, w_next;

  logic          r_is_store;
  logic [2:0]    r_func3;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [4:0]    r_rd;
  logic [31:0]   r_rdata_ext;
  logic [CW-1:0] r_cnt;

  logic        w_op_ok;
  logic        w_accept;
  logic        w_misalign;
  logic        w_tmo;
  logic [3:0]  w_strb;
  logic [31:0] w_lane_data;
  logic [31:0] w_shifted;
  logic [31:0] w_ext;

  assign w_op_ok    = (i_req_opcode == OP_LOAD) || (i_req_opcode == OP_STORE);
  assign w_accept   = i_req_valid && (r_state == S_IDLE) && w_op_ok;
  assign w_misalign = ((i_req_func3[1:0] == 2'b01) && i_req_addr[0]) ||
                      (i_req_func3[1] && (i_req_addr[1:0] != 2'b00));
  // The last waiting cycle before giving up is TIMEOUT_CYC-1 counted from entry.
  assign w_tmo      = TMO_EN && (r_cnt == TC_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_misalign ? S_EXC : S_REQ;
      end
      S_REQ: begin
        if (i_mem_gnt) begin
`ifdef LSU_STORE_ACK_EN
          w_next = S_WAIT_R;
`else
          w_next = r_is_store ? S_IDLE : S_WAIT_R;
`endif
        end else if (w_tmo) begin
          w_next = S_ERR;
        end
      end
      S_WAIT_R: begin
        if (i_mem_rvalid)  w_next = r_is_store ? S_IDLE : S_RESP;
        else if (w_tmo)    w_next = S_ERR;
      end
      S_RESP:  w_next = S_IDLE;
      S_EXC:   w_next = S_IDLE;
      S_ERR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_next != r_state) begin
      r_cnt <= '0;
    end else if (r_cnt != {CW{1'b1}}) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_is_store  <= 1'b0;
      r_func3     <= 3'b000;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rd        <= '0;
      r_rdata_ext <= '0;
    end else begin
      if (w_accept) begin
        r_is_store <= (i_req_opcode == OP_STORE);
        r_func3    <= i_req_func3;
        r_addr     <= i_req_addr;
        r_wdata    <= i_req_wdata;
        r_rd       <= i_req_rd;
      end
      if ((r_state == S_WAIT_R) && i_mem_rvalid) r_rdata_ext <= w_ext;
    end
  end

  always_comb begin
    w_strb      = 4'b1111;
    w_lane_data = r_wdata;
    case (r_func3[1:0])
      2'b00: begin
        w_strb      = 4'b0001 << r_addr[1:0];
        w_lane_data = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_strb      = 4'b0011 << r_addr[1:0];
        w_lane_data = {2{r_wdata[15:0]}};
      end
      default: begin
        w_strb      = 4'b1111;
        w_lane_data = r_wdata;
      end
    endcase
  end

  assign w_shifted = i_mem_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_ext = i_mem_rdata;
    case (r_func3[1:0])
      2'b00:   w_ext = r_func3[2] ? {24'b0, w_shifted[7:0]}
                                  : {{24{w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_ext = r_func3[2] ? {16'b0, w_shifted[15:0]}
                                  : {{16{w_shifted[15]}}, w_shifted[15:0]};
      default: w_ext = i_mem_rdata;
    endcase
  end

  assign o_req_ready    = (r_state == S_IDLE);
  assign o_busy         = (r_state != S_IDLE);
  assign o_mem_req      = (r_state == S_REQ);
  assign o_mem_we       = o_mem_req && r_is_store;
  assign o_mem_addr     = o_mem_req ? {r_addr[31:2], 2'b00} : 32'h0;
  assign o_mem_wstrb    = o_mem_we ? w_strb : 4'b0000;
  assign o_mem_wdata    = o_mem_we ? w_lane_data : 32'h0;
  assign o_wb_valid     = (r_state == S_RESP);
  assign o_wb_rd        = o_wb_valid ? r_rd : 5'd0;
  assign o_wb_data      = o_wb_valid ? r_rdata_ext : 32'h0;
  assign o_misalign_exc = (r_state == S_EXC);
  assign o_bus_err      = (r_state == S_ERR);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed table, reset corner case, and randomized ops
// checked against a cycle-timeline reference model.
module tb_lsu_ctrl;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [4:0]  req_opcode;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_exc, bus_err, busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT_CYC(T)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_opcode(req_opcode), .i_req_func3(req_func3),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_rd(req_rd),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wstrb(mem_wstrb), .o_mem_wdata(mem_wdata),
    .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid), .i_mem_rdata(mem_rdata),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_misalign_exc(misalign_exc), .o_bus_err(bus_err), .o_busy(busy)
  );

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          g;
    int          r;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_wb;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit m_misalign(input logic [2:0] f3, input logic [1:0] a);
    return (int'(a) % m_size(f3)) != 0;
  endfunction

  function automatic logic [3:0] m_strb(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] s;
    int n;
    n = m_size(f3);
    s = '0;
    for (int i = 0; i < 4; i++) s[i] = (i >= int'(a)) && (i < int'(a) + n);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] o;
    int n;
    n = m_size(f3);
    for (int i = 0; i < 4; i++) o[8*i +: 8] = wd[8*(i % n) +: 8];
    return o;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [1:0] a,
                                         input logic [31:0] w);
    logic [31:0] mask, v;
    int n;
    n = m_size(f3);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8*n)) - 32'h1);
    v = (w >> (8*int'(a))) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic vec_t mk(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [4:0] rd, input int g, input int r,
                              input logic [31:0] e_addr, input logic [3:0] e_strb,
                              input logic [31:0] e_wdata, input logic [31:0] e_wb);
    vec_t v;
    v.op = op; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
    v.g = g; v.r = r; v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata; v.e_wb = e_wb;
    return v;
  endfunction

  // Caller is at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_op(input vec_t v);
    bit ld, st, waits, mis;
    int end_c, req_last, gnt_c, rv_c, wb_c, exc_c, err_c;
    ld = (v.op == 5'b00000);
    st = (v.op == 5'b01000);
    req_opcode = v.op; req_func3 = v.f3; req_addr = v.addr;
    req_wdata = v.wdata; req_rd = v.rd; req_valid = 1'b1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    chk("ready_at_issue", req_ready, 1'b1);
    if (!ld && !st) begin
      @(negedge clk);
      req_valid = 1'b0;
      chk("bad_opcode_ignored", {req_ready, busy, mem_req}, 3'b100);
      return;
    end
    waits = ld;
`ifdef LSU_STORE_ACK_EN
    waits = 1'b1;
`endif
    mis = m_misalign(v.f3, v.addr[1:0]);
    gnt_c = 0; rv_c = 0; wb_c = 0; exc_c = 0; err_c = 0;
    if (mis) begin
      exc_c = 1; req_last = 0; end_c = 2;
    end else if (v.g >= T) begin
      req_last = T; err_c = T + 1; end_c = T + 2;
    end else begin
      gnt_c = 1 + v.g; req_last = gnt_c;
      if (!waits) end_c = gnt_c + 1;
      else if (v.r >= T) begin
        err_c = gnt_c + 1 + T; end_c = err_c + 1;
      end else begin
        rv_c = gnt_c + 1 + v.r;
        if (ld) begin wb_c = rv_c + 1; end_c = wb_c + 1; end
        else end_c = rv_c + 1;
      end
    end
    for (int c = 1; c <= end_c; c++) begin
      @(negedge clk);
      if (c == 1) begin
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      end
      chk("flags", {req_ready, busy, mem_req, wb_valid, misalign_exc, bus_err},
          {(c >= end_c), (c < end_c), (c <= req_last), (c == wb_c), (c == exc_c), (c == err_c)});
      if (c <= req_last) begin
        chk("mem_we_addr", {mem_we, mem_addr}, {st, v.e_addr});
        if (st) chk("mem_store_lanes", {mem_wstrb, mem_wdata}, {v.e_strb, v.e_wdata});
        else    chk("mem_load_strb", mem_wstrb, 4'b0000);
      end
      if (c == wb_c) chk("wb_rd_data", {wb_rd, wb_data}, {v.rd, v.e_wb});
      mem_gnt    = (c == gnt_c);
      mem_rvalid = (c == rv_c) || ((c == gnt_c) && ($urandom_range(0, 1) == 1));
      mem_rdata  = (c == rv_c) ? v.rdata : $urandom;
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  vec_t tbl[16];

  initial begin
    vec_t v;
    int k;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int sel;
    logic [2:0] ld_f3[5];
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010; ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;

    tbl[0]  = mk(5'b00000, 3'b010, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 5'd7, 0, 0,
                 32'h0000_1004, 4'h0, 32'h0, 32'hDEAD_BEEF);
    tbl[1]  = mk(5'b00000, 3'b000, 32'h0000_2003, 32'h0, 32'h8011_2233, 5'd1, 0, 0,
                 32'h0000_2000, 4'h0, 32'h0, 32'hFFFF_FF80);
    tbl[2]  = mk(5'b00000, 3'b100, 32'h0000_2003, 32'h0, 32'h8011_2233, 5'd2, 1, 1,
                 32'h0000_2000, 4'h0, 32'h0, 32'h0000_0080);
    tbl[3]  = mk(5'b00000, 3'b001, 32'h0000_2002, 32'h0, 32'h8011_2233, 5'd3, 0, 2,
                 32'h0000_2000, 4'h0, 32'h0, 32'hFFFF_8011);
    tbl[4]  = mk(5'b00000, 3'b101, 32'h0000_2002, 32'h0, 32'h8011_2233, 5'd4, 2, 0,
                 32'h0000_2000, 4'h0, 32'h0, 32'h0000_8011);
    tbl[5]  = mk(5'b00000, 3'b000, 32'h0000_2001, 32'h0, 32'h8011_2233, 5'd5, 0, 0,
                 32'h0000_2000, 4'h0, 32'h0, 32'h0000_0022);
    tbl[6]  = mk(5'b01000, 3'b000, 32'h0000_0102, 32'h0000_00A5, 32'h0, 5'd0, 0, 0,
                 32'h0000_0100, 4'b0100, 32'hA5A5_A5A5, 32'h0);
    tbl[7]  = mk(5'b01000, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 32'h0, 5'd0, 1, 0,
                 32'h0000_0100, 4'b1100, 32'hABCD_ABCD, 32'h0);
    tbl[8]  = mk(5'b01000, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 32'h0, 5'd0, 2, 0,
                 32'h0000_0200, 4'b1111, 32'hCAFE_F00D, 32'h0);
    tbl[9]  = mk(5'b00000, 3'b010, 32'h0000_1002, 32'h0, 32'h0, 5'd9, 0, 0,
                 32'h0, 4'h0, 32'h0, 32'h0);
    tbl[10] = mk(5'b01000, 3'b001, 32'h0000_1001, 32'h5555_5555, 32'h0, 5'd0, 0, 0,
                 32'h0, 4'h0, 32'h0, 32'h0);
    tbl[11] = mk(5'b00000, 3'b010, 32'h0000_3000, 32'h0, 32'h1111_1111, 5'd11, T, 0,
                 32'h0000_3000, 4'h0, 32'h0, 32'h0);
    tbl[12] = mk(5'b00000, 3'b010, 32'h0000_3004, 32'h0, 32'h2222_2222, 5'd12, 1, T,
                 32'h0000_3004, 4'h0, 32'h0, 32'h0);
    tbl[13] = mk(5'b01000, 3'b010, 32'h0000_3008, 32'h3333_3333, 32'h0, 5'd0, T + 1, 0,
                 32'h0000_3008, 4'b1111, 32'h3333_3333, 32'h0);
    tbl[14] = mk(5'b00100, 3'b010, 32'h0000_4000, 32'h0, 32'h0, 5'd14, 0, 0,
                 32'h0, 4'h0, 32'h0, 32'h0);
    tbl[15] = mk(5'b00000, 3'b010, 32'h0000_400C, 32'h0, 32'h7654_3210, 5'd15, T - 1, T - 1,
                 32'h0000_400C, 4'h0, 32'h0, 32'h7654_3210);

    rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_func3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk("reset_flags", {req_ready, busy, mem_req, mem_we, wb_valid, misalign_exc, bus_err},
        7'b1000000);
    chk("reset_buses", {mem_addr, mem_wdata}, 64'h0);
    chk("reset_wb", {mem_wstrb, wb_rd, wb_data}, 41'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++) run_op(tbl[i]);

    // Reset while waiting for read data, then a stale rvalid.
    req_opcode = 5'b00000; req_func3 = 3'b010; req_addr = 32'h0000_5000;
    req_rd = 5'd21; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("mid_wait_busy", {busy, mem_req}, 2'b10);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_flags", {req_ready, busy, mem_req, mem_we, wb_valid, misalign_exc, bus_err},
        7'b1000000);
    chk("async_rst_buses", {mem_addr, wb_data}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      chk("stale_rvalid_no_wb", {wb_valid, busy, bus_err}, 3'b000);
    end

    for (int n = 0; n < 120; n++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        v.op = 5'($urandom);
        if (v.op == 5'b00000 || v.op == 5'b01000) v.op = 5'b11011;
        v.f3 = 3'($urandom);
      end else if (sel < 6) begin
        v.op = 5'b00000;
        v.f3 = ld_f3[$urandom_range(0, 4)];
      end else begin
        v.op = 5'b01000;
        v.f3 = 3'($urandom_range(0, 2));
      end
      v.addr  = $urandom;
      v.wdata = $urandom;
      v.rdata = $urandom;
      v.rd    = 5'($urandom);
      v.g = ($urandom_range(0, 6) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, 2);
      v.r = ($urandom_range(0, 6) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, 2);
      v.e_addr  = {v.addr[31:2], 2'b00};
      v.e_strb  = m_strb(v.f3, v.addr[1:0]);
      v.e_wdata = m_wdata(v.f3, v.wdata);
      v.e_wb    = m_load(v.f3, v.addr[1:0], v.rdata);
      run_op(v);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
